// File: rtl/tl_pkg.sv
// TileLink-UL opcode constants, responder FSM encoding and burst-length helper.
// Shared by the memory responder and its backing store.
package tl_pkg;

   localparam logic [2:0] TL_A_PUT_FULL    = 3'd0;
   localparam logic [2:0] TL_A_PUT_PARTIAL = 3'd1;
   localparam logic [2:0] TL_A_GET         = 3'd4;

   localparam logic [2:0] TL_D_ACK         = 3'd0;
   localparam logic [2:0] TL_D_ACK_DATA    = 3'd1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WRDATA,
      ST_WAIT,
      ST_RESP
   } tl_state_e;

   // Index of the final 64-bit beat for a log2-bytes size; sizes above 6 clamp to 8 beats.
   function automatic logic [2:0] tl_last_beat(input logic [2:0] size);
      logic [2:0] last;
      case (size)
         3'd4:    last = 3'd1;
         3'd5:    last = 3'd3;
         3'd6,
         3'd7:    last = 3'd7;
         default: last = 3'd0;
      endcase
      return last;
   endfunction

endpackage

// File: rtl/rv64g_tl_mem_array.sv
// Backing store: WORDS x 64 bits, synchronous byte-masked write, combinational read, no reset.
// Single cycle write, zero cycle read; always ready.
module rv64g_tl_mem_array #(
   parameter int unsigned WORDS = 1024,
   parameter int unsigned IDX_W = 10
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [IDX_W-1:0] widx_i,
   input  logic [63:0]      wdat_i,
   input  logic [7:0]       wmask_i,
   input  logic [IDX_W-1:0] ridx_i,
   output logic [63:0]      rdat_o
);

   logic [63:0] mem_q [WORDS];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int b = 0; b < 8; b++) begin
            if (wmask_i[b]) begin
               mem_q[widx_i][b*8 +: 8] <= wdat_i[b*8 +: 8];
            end
         end
      end
   end

   assign rdat_o = mem_q[ridx_i];

endmodule

// File: rtl/rv64g_tl_mem_responder.sv
// TileLink-UL memory slave, one transaction in flight; first D beat LATENCY+1 cycles after accept.
// A is accepted only in IDLE/WRDATA; D outputs are registered and hold while mem_d_ready_i is low.
module rv64g_tl_mem_responder
   import tl_pkg::*;
#(
   parameter int unsigned       ADDR_W    = 64,
   parameter int unsigned       DATA_W    = 64,
   parameter int unsigned       MEM_WORDS = 1024,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int unsigned       LATENCY   = 2
) (
   input  logic              clk_i,
   input  logic              rst_ni,

   input  logic [2:0]        mem_a_opcode_i,
   input  logic [2:0]        mem_a_param_i,
   input  logic [2:0]        mem_a_size_i,
   input  logic [3:0]        mem_a_source_i,
   input  logic [ADDR_W-1:0] mem_a_address_i,
   input  logic [7:0]        mem_a_mask_i,
   input  logic [DATA_W-1:0] mem_a_data_i,
   input  logic              mem_a_valid_i,
   output logic              mem_a_ready_o,

   output logic [2:0]        mem_d_opcode_o,
   output logic [1:0]        mem_d_param_o,
   output logic [2:0]        mem_d_size_o,
   output logic [3:0]        mem_d_source_o,
   output logic [1:0]        mem_d_sink_o,
   output logic              mem_d_denied_o,
   output logic [DATA_W-1:0] mem_d_data_o,
   output logic              mem_d_corrupt_o,
   output logic              mem_d_valid_o,
   input  logic              mem_d_ready_i
);

   localparam int unsigned       IDX_W   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam logic [ADDR_W:0]   MEM_LIM = (ADDR_W+1)'(MEM_WORDS);
   localparam logic [3:0]        LAT_LD  = 4'(LATENCY);

   tl_state_e        state_q;
   logic             a_rdy_q;
   logic [2:0]       opc_q;
   logic [2:0]       size_q;
   logic [3:0]       src_q;
   logic [IDX_W-1:0] base_q;
   logic [2:0]       last_q;
   logic [2:0]       beat_q;
   logic [3:0]       lat_q;
   logic             err_q;
   logic             d_vld_q;
   logic [DATA_W-1:0] d_dat_q;

   logic             a_fire;
   logic             a_is_put;
   logic             a_is_get;
   logic [2:0]       a_last;
   logic [ADDR_W:0]  a_diff;
   logic [ADDR_W:0]  a_lastw;
   logic             a_err;
   logic [IDX_W-1:0] a_word;
   logic             is_get_q;
   logic             resp_last;
   logic [2:0]       rd_beat;
   logic [IDX_W-1:0] rd_idx;
   logic [63:0]      rd_dat;
   logic [DATA_W-1:0] rd_val;
   logic             mem_we;
   logic [IDX_W-1:0] mem_widx;
   logic             unused_ok;

   assign a_fire   = mem_a_valid_i & a_rdy_q;
   assign a_is_put = (mem_a_opcode_i == TL_A_PUT_FULL) || (mem_a_opcode_i == TL_A_PUT_PARTIAL);
   assign a_is_get = (mem_a_opcode_i == TL_A_GET);
   assign a_last   = (a_is_put || a_is_get) ? tl_last_beat(mem_a_size_i) : 3'd0;

   // Extra top bit of the subtraction flags an address below BASE_ADDR.
   assign a_diff   = {1'b0, mem_a_address_i} - {1'b0, BASE_ADDR};
   assign a_lastw  = {4'b0, a_diff[ADDR_W-1:3]} + (ADDR_W+1)'(a_last);
   assign a_err    = !(a_is_put || a_is_get) || a_diff[ADDR_W] || (a_lastw >= MEM_LIM);
   assign a_word   = a_diff[IDX_W+2:3];

   assign is_get_q  = (opc_q == TL_A_GET);
   assign resp_last = !is_get_q || (beat_q == last_q);
   assign rd_beat   = d_vld_q ? beat_q + 3'd1 : beat_q;
   assign rd_idx    = base_q + IDX_W'(rd_beat);
   assign rd_val    = (err_q || !is_get_q) ? '0 : rd_dat;

   always_comb begin
      mem_we   = 1'b0;
      mem_widx = a_word;
      if (state_q == ST_IDLE) begin
         mem_we = a_fire && a_is_put && !a_err;
      end else if (state_q == ST_WRDATA) begin
         mem_we   = a_fire && !err_q;
         mem_widx = base_q + IDX_W'(beat_q) + IDX_W'(1);
      end
   end

   rv64g_tl_mem_array #(
      .WORDS (MEM_WORDS),
      .IDX_W (IDX_W)
   ) u_array (
      .clk_i   (clk_i),
      .we_i    (mem_we),
      .widx_i  (mem_widx),
      .wdat_i  (mem_a_data_i),
      .wmask_i (mem_a_mask_i),
      .ridx_i  (rd_idx),
      .rdat_o  (rd_dat)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         a_rdy_q <= 1'b0;
         opc_q   <= '0;
         size_q  <= '0;
         src_q   <= '0;
         base_q  <= '0;
         last_q  <= '0;
         beat_q  <= '0;
         lat_q   <= '0;
         err_q   <= 1'b0;
         d_vld_q <= 1'b0;
         d_dat_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               a_rdy_q <= 1'b1;
               if (a_fire) begin
                  opc_q  <= mem_a_opcode_i;
                  size_q <= mem_a_size_i;
                  src_q  <= mem_a_source_i;
                  base_q <= a_word;
                  last_q <= a_last;
                  err_q  <= a_err;
                  beat_q <= '0;
                  if (a_is_put && (a_last != 3'd0)) begin
                     state_q <= ST_WRDATA;
                  end else begin
                     state_q <= ST_WAIT;
                     lat_q   <= LAT_LD;
                     a_rdy_q <= 1'b0;
                  end
               end
            end
            ST_WRDATA: begin
               if (a_fire) begin
                  beat_q <= beat_q + 3'd1;
                  if (beat_q + 3'd1 == last_q) begin
                     state_q <= ST_WAIT;
                     lat_q   <= LAT_LD;
                     a_rdy_q <= 1'b0;
                     beat_q  <= '0;
                  end
               end
            end
            ST_WAIT: begin
               lat_q <= lat_q - 4'd1;
               if (lat_q == 4'd1) begin
                  state_q <= ST_RESP;
               end
            end
            ST_RESP: begin
               // First RESP cycle loads beat 0; afterwards each fire loads the next beat.
               if (!d_vld_q) begin
                  d_vld_q <= 1'b1;
                  d_dat_q <= rd_val;
               end else if (mem_d_ready_i) begin
                  if (resp_last) begin
                     d_vld_q <= 1'b0;
                     state_q <= ST_IDLE;
                     a_rdy_q <= 1'b1;
                     beat_q  <= '0;
                  end else begin
                     beat_q  <= beat_q + 3'd1;
                     d_dat_q <= rd_val;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign mem_a_ready_o   = a_rdy_q;
   assign mem_d_opcode_o  = is_get_q ? TL_D_ACK_DATA : TL_D_ACK;
   assign mem_d_param_o   = 2'd0;
   assign mem_d_size_o    = size_q;
   assign mem_d_source_o  = src_q;
   assign mem_d_sink_o    = 2'd0;
   assign mem_d_denied_o  = err_q;
   assign mem_d_data_o    = d_dat_q;
   assign mem_d_corrupt_o = err_q && is_get_q;
   assign mem_d_valid_o   = d_vld_q;

   assign unused_ok = ^{mem_a_param_i, a_diff[2:0]};

endmodule

// File: tb/tb_rv64g_tl_mem_responder.sv
// Directed bench for rv64g_tl_mem_responder: puts, gets, bursts, backpressure, errors, reset.
module tb_rv64g_tl_mem_responder;

   localparam int unsigned ADDR_W    = 64;
   localparam int unsigned DATA_W    = 64;
   localparam int unsigned MEM_WORDS = 1024;
   localparam int unsigned LAT       = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [2:0]        a_op, a_param, a_size;
   logic [3:0]        a_src;
   logic [ADDR_W-1:0] a_addr;
   logic [7:0]        a_mask;
   logic [DATA_W-1:0] a_dat;
   logic              a_vld, a_rdy;
   logic [2:0]        d_op, d_size;
   logic [1:0]        d_param, d_sink;
   logic [3:0]        d_src;
   logic              d_den, d_cor, d_vld, d_rdy;
   logic [DATA_W-1:0] d_dat;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int acc_cyc;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   rv64g_tl_mem_responder #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .MEM_WORDS (MEM_WORDS),
      .BASE_ADDR (64'd0),
      .LATENCY   (LAT)
   ) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .mem_a_opcode_i  (a_op),
      .mem_a_param_i   (a_param),
      .mem_a_size_i    (a_size),
      .mem_a_source_i  (a_src),
      .mem_a_address_i (a_addr),
      .mem_a_mask_i    (a_mask),
      .mem_a_data_i    (a_dat),
      .mem_a_valid_i   (a_vld),
      .mem_a_ready_o   (a_rdy),
      .mem_d_opcode_o  (d_op),
      .mem_d_param_o   (d_param),
      .mem_d_size_o    (d_size),
      .mem_d_source_o  (d_src),
      .mem_d_sink_o    (d_sink),
      .mem_d_denied_o  (d_den),
      .mem_d_data_o    (d_dat),
      .mem_d_corrupt_o (d_cor),
      .mem_d_valid_o   (d_vld),
      .mem_d_ready_i   (d_rdy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] op, input logic [2:0] sz, input logic [3:0] src,
                       input logic [63:0] addr, input logic [7:0] mask, input logic [63:0] dat);
      int n = 0;
      a_op = op; a_size = sz; a_src = src; a_addr = addr; a_mask = mask; a_dat = dat;
      a_vld = 1'b1;
      while (!a_rdy && n < 50) begin
         tick();
         n++;
      end
      if (!a_rdy) chk("a_ready_timeout", {63'd0, a_rdy}, 64'd1);
      tick();
      acc_cyc = cyc;
      a_vld = 1'b0;
   endtask

   task automatic wait_d();
      int n = 0;
      while (!d_vld && n < 50) begin
         tick();
         n++;
      end
      if (!d_vld) chk("d_valid_timeout", {63'd0, d_vld}, 64'd1);
   endtask

   task automatic get1(input string tag, input logic [63:0] addr, input logic [63:0] exp);
      send(3'd4, 3'd3, 4'd5, addr, 8'hFF, 64'd0);
      wait_d();
      chk({tag, "_opcode"}, {61'd0, d_op}, 64'd1);
      chk({tag, "_data"}, d_dat, exp);
      chk({tag, "_denied"}, {63'd0, d_den}, 64'd0);
      tick();
   endtask

   task automatic put_burst(input logic [63:0] addr, input logic [63:0] first);
      for (int i = 0; i < 8; i++) begin
         send(3'd0, 3'd6, 4'd2, addr, 8'hFF, first + 64'(i));
      end
   endtask

   initial begin
      int got, viol, extra, k;
      logic stalled;
      logic [63:0] prev_dat;
      logic [2:0]  prev_op;
      logic [3:0]  pat;

      rst_n = 1'b0; d_rdy = 1'b1; a_vld = 1'b0; a_param = 3'd0;
      a_op = 3'd0; a_size = 3'd0; a_src = 4'd0; a_addr = '0; a_mask = '0; a_dat = '0;
      tick();
      chk("rst_d_valid", {63'd0, d_vld}, 64'd0);
      chk("rst_a_ready", {63'd0, a_rdy}, 64'd0);
      chk("rst_d_data", d_dat, 64'd0);
      chk("rst_d_opcode", {61'd0, d_op}, 64'd0);
      tick();
      rst_n = 1'b1;
      tick(); tick();
      chk("idle_a_ready", {63'd0, a_rdy}, 64'd1);

      // Full put then get
      send(3'd0, 3'd3, 4'd3, 64'h40, 8'hFF, 64'h1122334455667788);
      wait_d();
      chk("put_latency", 64'(cyc - acc_cyc), 64'(LAT + 1));
      chk("put_opcode", {61'd0, d_op}, 64'd0);
      chk("put_source", {60'd0, d_src}, 64'd3);
      chk("put_denied", {63'd0, d_den}, 64'd0);
      tick();
      get1("get_full", 64'h40, 64'h1122334455667788);
      chk("get_source", {60'd0, d_src}, 64'd5);

      // Partial put, low address bits ignored on readback
      send(3'd1, 3'd3, 4'd1, 64'h40, 8'h0F, 64'hAAAAAAAAAAAAAAAA);
      wait_d();
      chk("pput_opcode", {61'd0, d_op}, 64'd0);
      tick();
      get1("get_partial", 64'h47, 64'h11223344AAAAAAAA);

      // 8-beat burst put, single ack
      put_burst(64'h100, 64'd1);
      wait_d();
      chk("burst_ack_opcode", {61'd0, d_op}, 64'd0);
      chk("burst_ack_size", {61'd0, d_size}, 64'd6);
      tick();
      extra = 0;
      for (int i = 0; i < 6; i++) begin
         if (d_vld) extra++;
         tick();
      end
      chk("burst_single_ack", 64'(extra), 64'd0);

      // Burst get
      send(3'd4, 3'd6, 4'd7, 64'h100, 8'hFF, 64'd0);
      wait_d();
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("burst_get_beat%0d", i), d_dat, 64'(i + 1));
         if (i == 0) chk("burst_get_size", {61'd0, d_size}, 64'd6);
         tick();
      end
      chk("burst_get_done", {63'd0, d_vld}, 64'd0);

      // Backpressure with ready pattern 1,0,0,1
      send(3'd4, 3'd6, 4'd7, 64'h100, 8'hFF, 64'd0);
      pat = 4'b1001; got = 0; viol = 0; k = 0; stalled = 1'b0;
      prev_dat = '0; prev_op = '0;
      for (int n = 0; n < 200 && got < 8; n++) begin
         d_rdy = pat[k % 4];
         k++;
         if (a_rdy) viol++;
         if (d_vld) begin
            if (stalled) begin
               chk("bp_data_stable", d_dat, prev_dat);
               chk("bp_opcode_stable", {61'd0, d_op}, {61'd0, prev_op});
            end
            if (d_rdy) begin
               chk($sformatf("bp_beat%0d", got), d_dat, 64'(got + 1));
               got++;
            end
            stalled = !d_rdy;
            prev_dat = d_dat;
            prev_op = d_op;
         end else begin
            stalled = 1'b0;
         end
         tick();
      end
      d_rdy = 1'b1;
      chk("bp_beats", 64'(got), 64'd8);
      chk("bp_a_ready_low", 64'(viol), 64'd0);
      chk("bp_no_extra", {63'd0, d_vld}, 64'd0);

      // Out-of-range get
      send(3'd4, 3'd3, 4'd9, 64'(MEM_WORDS * 8), 8'hFF, 64'd0);
      wait_d();
      chk("oor_get_denied", {63'd0, d_den}, 64'd1);
      chk("oor_get_corrupt", {63'd0, d_cor}, 64'd1);
      chk("oor_get_data", d_dat, 64'd0);
      tick();

      // Unsupported opcode
      send(3'd6, 3'd3, 4'd4, 64'h40, 8'hFF, 64'hDEADBEEFDEADBEEF);
      wait_d();
      chk("badop_opcode", {61'd0, d_op}, 64'd0);
      chk("badop_denied", {63'd0, d_den}, 64'd1);
      tick();
      get1("badop_nowrite", 64'h40, 64'h11223344AAAAAAAA);

      // Burst whose last beat crosses the end of memory
      send(3'd0, 3'd3, 4'd1, 64'h1FC8, 8'hFF, 64'hCAFEF00D12345678);
      wait_d();
      tick();
      put_burst(64'h1FC8, 64'h50);
      wait_d();
      chk("oor_put_denied", {63'd0, d_den}, 64'd1);
      tick();
      get1("oor_put_nowrite", 64'h1FC8, 64'hCAFEF00D12345678);

      // Reset while the third beat of a burst get is presented
      send(3'd4, 3'd6, 4'd7, 64'h100, 8'hFF, 64'd0);
      wait_d();
      tick(); tick();
      chk("rst_mid_beat3", d_dat, 64'd3);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", {63'd0, d_vld}, 64'd0);
      chk("rst_mid_a_ready", {63'd0, a_rdy}, 64'd0);
      tick();
      rst_n = 1'b1;
      tick();
      get1("after_reset", 64'h100, 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rv64g_tl_mem_responder.md
RV64G_TL_MEM_RESPONDER -- requirements
Module: rv64g_tl_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, address width.
REQ-002 SHALL have parameter DATA_W, default 64, beat width (fixed 64; 8 bytes per beat).
REQ-003 SHALL have parameter MEM_WORDS, default 1024, backing-store depth in 64-bit words.
REQ-004 SHALL have parameter BASE_ADDR, default 0, first byte address served.
REQ-005 SHALL have parameter LATENCY, default 2, access wait cycles, range 1..15.
REQ-006 SHALL have ports:
- clk_i  in  1  clock; single clock domain.
- rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have A-channel input ports:
- mem_a_opcode_i  in  3  opcode
- mem_a_param_i  in  3  ignored
- mem_a_size_i  in  3  log2 bytes
- mem_a_source_i  in  4  request ID
- mem_a_address_i  in  ADDR_W  byte address
- mem_a_mask_i  in  8  byte lanes
- mem_a_data_i  in  DATA_W  write data
- mem_a_valid_i  in  1  request valid
- mem_a_ready_o  out  1  request accepted
REQ-008 SHALL have D-channel output ports:
- mem_d_opcode_o  out  3
- mem_d_param_o  out  2  always 0
- mem_d_size_o  out  3  echoes request size
- mem_d_source_o  out  4  echoes request source
- mem_d_sink_o  out  2  always 0
- mem_d_denied_o  out  1
- mem_d_data_o  out  DATA_W
- mem_d_corrupt_o  out  1
- mem_d_valid_o  out  1
- mem_d_ready_i  in  1

Function
REQ-009 SHALL support Get(4)->AccessAckData(1), PutFullData(0) and PutPartialData(1)->AccessAck(0).
REQ-010 SHALL compute beats = 2^(size-3) for size>=3, else 1; size capped at 6 (8 beats).
REQ-011 SHALL use FSM IDLE, WRDATA, WAIT, RESP; exactly one transaction outstanding.
REQ-012 SHALL drive mem_a_ready_o=1 only in IDLE and WRDATA.
REQ-013 IDLE: on A fire, latch opcode, size, source, address; reset beat counter to 0.
REQ-013a IDLE transitions: to WRDATA for a multi-beat Put, otherwise to WAIT with the latency counter loaded to LATENCY.
REQ-014 Put beats SHALL write mem_a_data_i under mem_a_mask_i in the accept cycle, at word ((addr-BASE_ADDR)>>3)+beat.
REQ-015 WRDATA: after the last Put beat fires, go to WAIT; the header fields of later beats are ignored.
REQ-016 WAIT: decrement the counter each cycle; go to RESP when it reaches 1.
REQ-016a Request-accept to first mem_d_valid_o SHALL be LATENCY+1 cycles for single-beat requests.
REQ-017 RESP, Put: emit one AccessAck beat; on fire, return to IDLE.
REQ-017a RESP, Get: emit `beats` AccessAckData beats, data from word base+beat; on the last fire, return to IDLE.
REQ-018 While mem_d_valid_o=1 and mem_d_ready_i=0, all D outputs SHALL hold stable.
REQ-019 Back-to-back: a new A SHALL be accepted no earlier than the cycle after the final D fire.
REQ-020 Out-of-range request SHALL NOT write; response has denied=1.
REQ-020a Out-of-range test: any beat word index >= MEM_WORDS, or address < BASE_ADDR.
REQ-020b Out-of-range Get SHALL return data=0 and corrupt=1 on every beat.
REQ-021 Unsupported opcode SHALL be accepted as single-beat and answered with AccessAck, denied=1, with no memory effect.
REQ-022 The low 3 address bits SHALL be ignored for word indexing; masks apply as given.

Reset
REQ-023 On rst_ni low: FSM goes to IDLE; counters go to 0; mem_d_valid_o=0; mem_a_ready_o=0 while in reset.
REQ-023a On rst_ni low: all other D outputs go to 0.
REQ-024 Reset mid-transaction SHALL abandon it without a response; Put beats already written remain written.
REQ-025 Backing-store contents SHALL NOT be cleared by reset.

Structure
REQ-026 TileLink opcode constants (Get, PutFull, PutPartial, AccessAck, AccessAckData) and the FSM state encoding SHALL live in shared package tl_pkg.
REQ-027 Backing store SHALL be sub-module rv64g_tl_mem_array: MEM_WORDS x 64, synchronous byte-masked write, combinational read.

Verification
REQ-028 Full Put then Get: PutFull size=3, addr 0x40, data 0x1122334455667788, mask FF, src 3.
- Put response: AccessAck src 3 arrives LATENCY+1 cycles after accept.
- Get size=3, addr 0x40: AccessAckData with data 0x1122334455667788, denied=0.
REQ-029 Partial write: PutPartial addr 0x40, mask 0x0F, data 0xAAAAAAAAAAAAAAAA.
- Following Get returns 0x11223344AAAAAAAA.
REQ-030 Burst: 8-beat PutFull size=6 at 0x100, data i+1 on beat i.
- Exactly one AccessAck.
- Get size=6 returns beats 1..8 in order, size=6 echoed.
REQ-031 Backpressure: Get size=6 with mem_d_ready_i toggled 1,0,0,1.
- Data/opcode held stable while stalled.
- 8 beats total, no loss or duplicate.
- mem_a_ready_o=0 throughout.
REQ-032 Errors: Get at MEM_WORDS*8 -> denied=1, corrupt=1, data 0.
- opcode 6 -> AccessAck denied=1.
- Neither alters memory.
REQ-033 Reset during beat 3 of an 8-beat Get response -> mem_d_valid_o=0 immediately.
- Next request is serviced normally.
